mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the instruction-fetch unit
//  (requester IF) and the MEM-stage load/store path (requester D).
//  Non-pipelined: at most one transaction in flight.
//  Generates freeze_pc to hold the fetch PC and IF stage while a fetch is
//  pending.
//  Sits between the IFU/MEM stage and the shared memory model in the P5 top.
// PARAMETERS
//  LAT    2  memory read latency in cycles, >=1; rdata valid LAT cycles after mem_en
//  MAX_D  3  max consecutive D grants while IF is waiting before IF must be served
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  if_req     in   1   fetch request; held with if_addr until if_rvalid
//  if_addr    in   32  fetch byte address (PC)
//  if_rvalid  out  1   one-cycle pulse: if_rdata valid, fetch done
//  if_rdata   out  32  fetched instruction
//  d_req      in   1   data request; held with d_* until d_rvalid
//  d_we       in   1   1 = store, 0 = load
//  d_be       in   4   store byte enables
//  d_addr     in   32  data byte address
//  d_wdata    in   32  store data
//  d_rvalid   out  1   one-cycle pulse: load data valid / store complete
//  d_rdata    out  32  load data
//  mem_en     out  1   memory access strobe, one cycle per transaction
//  mem_we     out  1   memory write enable, qualified by mem_en
//  mem_be     out  4   memory byte enables
//  mem_addr   out  32  word-aligned byte address {addr[31:2],2'b00}
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, valid LAT cycles after mem_en
//  freeze_pc  out  1   if_req & ~if_rvalid; drives the IFU freeze input
// BEHAVIOUR
//  - Reset: state IDLE; starve_cnt=0; all outputs 0 (incl. freeze_pc).
//  - FSM IDLE->WAIT on grant; WAIT->IDLE when lat_cnt reaches 0.
//  - IDLE, any request: grant in the same cycle.
//    Grant drives mem_en=1 and mem_* from the winner's inputs (combinational).
//    Latch owner; load lat_cnt=LAT.
//  - Priority: D wins unless starve_cnt==MAX_D and if_req=1; then IF wins.
//  - starve_cnt: +1 on each D grant while if_req=1, saturating at MAX_D.
//    Cleared on IF grant, or in any cycle with if_req=0.
//  - Grant cycle G: owner's rvalid pulses at cycle G+LAT, with rdata=mem_rdata.
//    FSM is IDLE in that same cycle, so a new grant may issue at G+LAT.
//    Back-to-back throughput: 1 access / LAT cycles.
//  - Stores (mem_we=1): d_rvalid pulses at G+LAT as the completion ack;
//    d_rdata is don't-care.
//  - rdata outputs hold their last value between pulses.
//  - Request dropped after grant: transaction completes, rvalid still pulses.
//    Request dropped before grant: no effect.
//  - Simultaneous if_req & d_req in IDLE: resolved by priority rule, no loss;
//    the loser keeps req high and is served next.
//  - Reset mid-WAIT: transaction aborted; no rvalid pulse; FSM to IDLE next cycle.
//  - Address bits [1:0] ignored; no misalignment error is raised here.
// CONFIGURATION
//  ARB_PERF_EN defined: extra output ports if_stall_cnt[31:0] and d_grant_cnt[31:0].
//    Both reset to 0 and wrap at 2^32.
//    if_stall_cnt: +1 every cycle freeze_pc=1. d_grant_cnt: +1 per D grant.
//  ARB_PERF_EN undefined: counters and those ports omitted; behaviour unchanged.
// STRUCTURE
//  Package arb_pkg:
//    state encodings ST_IDLE / ST_WAIT; owner codes OWN_IF=1'b0, OWN_D=1'b1;
//    width constants for lat_cnt and starve_cnt ($clog2-derived).
//  Sub-module arb_lat_tracker: holds owner + lat_cnt; emits done pulse and owner.
//  Top holds the arbitration, mux and starvation logic.
// TESTING (LAT=2, MAX_D=3)
//  1. if_req only, addr 0x3000:
//     mem_en at G with mem_addr=0x3000; if_rvalid at G+2 with mem_rdata;
//     freeze_pc=1 in G..G+1, 0 at G+2.
//  2. if_req & d_req both at cycle 0:
//     D granted at 0, d_rvalid at 2; IF granted at 2, if_rvalid at 4.
//  3. d_req held high plus if_req:
//     3 D grants at cycles 0,2,4; 4th grant (cycle 6) goes to IF; D resumes at 8.
//  4. Store d_we=1, be=4'b0011, addr 0x0006:
//     mem_we=1, mem_be=0011, mem_addr=0x0004; d_rvalid at G+2.
//  5. reset asserted at G+1 of a load:
//     no d_rvalid; outputs 0; new if_req granted the cycle after reset drops.
//  6. ARB_PERF_EN, scenario 2:
//     if_stall_cnt=4, d_grant_cnt=1 after if_rvalid.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t  : arbiter FSM states (ST_IDLE, ST_WAIT)
//   OWN_IF/OWN_D : owner codes for the transaction in flight
//   cnt_width()  : width needed to hold 0..max_val
package arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int LAT_DEF   = 2;
  localparam int MAX_D_DEF = 3;

  // Counter width able to represent every value 0..max_val (at least 1 bit).
  function automatic int cnt_width(input int max_val);
    int w;
    if (max_val < 1) w = 1;
    else             w = $clog2(max_val + 1);
    return w;
  endfunction

  localparam int LAT_W_DEF    = cnt_width(LAT_DEF);
  localparam int STARVE_W_DEF = cnt_width(MAX_D_DEF);

endpackage

// File: rtl/arb_lat_tracker.sv
// arb_lat_tracker: remembers who owns the transaction in flight and counts
// down the memory read latency.
//   clk, reset   : clock, synchronous active-high reset
//   grant        : a new transaction is issued this cycle
//   grant_owner  : owner code of the new transaction
//   waiting      : arbiter is in ST_WAIT
//   done         : latency expired this cycle (read data / ack is due now)
//   owner        : owner of the transaction in flight
module arb_lat_tracker
  import arb_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic grant,
  input  logic grant_owner,
  input  logic waiting,
  output logic done,
  output logic owner
);

  // The grant cycle itself is the first latency cycle, so LAT-1 cycles of
  // counting remain once the FSM enters ST_WAIT.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT - 1);
  localparam logic [LAT_W-1:0] CNT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);

  logic [LAT_W-1:0] lat_cnt_r;
  logic             owner_r;

  // Owner latch and latency down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r   <= OWN_IF;
      lat_cnt_r <= CNT_ZERO;
    end else if (grant) begin
      owner_r   <= grant_owner;
      lat_cnt_r <= LAT_LOAD;
    end else if (waiting && (lat_cnt_r != CNT_ZERO)) begin
      lat_cnt_r <= lat_cnt_r - CNT_ONE;
    end else begin
      lat_cnt_r <= lat_cnt_r;
    end
  end

  assign done  = waiting & (lat_cnt_r == CNT_ZERO);
  assign owner = owner_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch (IF) and the load/store path (D). One transaction in flight at a time.
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr                  : fetch request, held until if_rvalid
//   if_rvalid/if_rdata              : fetch completion pulse and data
//   d_req/d_we/d_be/d_addr/d_wdata  : data request, held until d_rvalid
//   d_rvalid/d_rdata                : load data / store ack pulse
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata : memory request (grant cycle)
//   mem_rdata                       : memory read data, LAT cycles after mem_en
//   freeze_pc                       : holds the fetch PC while a fetch is pending
// Build option ARB_PERF_EN adds if_stall_cnt and d_grant_cnt output counters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int MAX_D = MAX_D_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        freeze_pc
`ifdef ARB_PERF_EN
  ,
  output logic [31:0] if_stall_cnt,
  output logic [31:0] d_grant_cnt
`endif
);

  localparam int LAT_W    = cnt_width(LAT);
  localparam int STARVE_W = cnt_width(MAX_D);
  localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(MAX_D);
  localparam logic [STARVE_W-1:0] STARVE_ZERO = {STARVE_W{1'b0}};
  localparam logic [STARVE_W-1:0] STARVE_ONE  = STARVE_W'(1);

  arb_state_t          state_r, state_next_s;
  logic [STARVE_W-1:0] starve_r, starve_next_s;
  logic                trk_done_s, done_s, owner_s;
  logic                can_grant_s, grant_s, grant_own_s;
  logic [31:0]         if_hold_r, d_hold_r;
  logic [3:0]          addr_unused_s;

  // Byte-offset bits never reach the memory; no misalignment check here.
  assign addr_unused_s = {if_addr[1:0], d_addr[1:0]};

  arb_lat_tracker #(.LAT(LAT), .LAT_W(LAT_W)) u_trk (
    .clk         (clk),
    .reset       (reset),
    .grant       (grant_s),
    .grant_owner (grant_own_s),
    .waiting     (state_r == ST_WAIT),
    .done        (trk_done_s),
    .owner       (owner_s)
  );

  // A reset aborts the transaction, so the completion pulse is suppressed.
  assign done_s = trk_done_s & ~reset;

  // The completion cycle counts as idle, giving back-to-back LAT-cycle issue.
  assign can_grant_s = ~reset & ((state_r == ST_IDLE) | done_s);
  assign grant_s     = can_grant_s & (if_req | d_req);
  // D has priority unless IF has already waited through MAX_D D grants.
  assign grant_own_s = (if_req & (~d_req | (starve_r == STARVE_MAX))) ? OWN_IF : OWN_D;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) state_next_s = ST_WAIT;
        else         state_next_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (grant_s)     state_next_s = ST_WAIT;
        else if (done_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Memory request mux: driven only in the grant cycle, zero otherwise.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    if (grant_s) begin
      mem_en = 1'b1;
      if (grant_own_s == OWN_IF) begin
        mem_addr = {if_addr[31:2], 2'b00};
        mem_be   = 4'b1111;
      end else begin
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = {d_addr[31:2], 2'b00};
        mem_wdata = d_wdata;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // Starvation counter next value: counts D grants that IF sat through.
  always_comb begin
    starve_next_s = starve_r;
    if (!if_req) begin
      starve_next_s = STARVE_ZERO;
    end else if (grant_s && (grant_own_s == OWN_IF)) begin
      starve_next_s = STARVE_ZERO;
    end else if (grant_s && (starve_r != STARVE_MAX)) begin
      starve_next_s = starve_r + STARVE_ONE;
    end else begin
      starve_next_s = starve_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) starve_r <= STARVE_ZERO;
    else       starve_r <= starve_next_s;
  end

  assign if_rvalid = done_s & (owner_s == OWN_IF);
  assign d_rvalid  = done_s & (owner_s == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : if_hold_r;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_hold_r;
  assign freeze_pc = if_req & ~if_rvalid & ~reset;

  // Read-data hold registers so rdata stays stable between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_hold_r <= 32'h0000_0000;
      d_hold_r  <= 32'h0000_0000;
    end else begin
      if (if_rvalid) if_hold_r <= mem_rdata;
      else           if_hold_r <= if_hold_r;
      if (d_rvalid)  d_hold_r  <= mem_rdata;
      else           d_hold_r  <= d_hold_r;
    end
  end

`ifdef ARB_PERF_EN
  // Performance counters: fetch-stall cycles and D grants, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_stall_cnt <= 32'd0;
      d_grant_cnt  <= 32'd0;
    end else begin
      if (freeze_pc) if_stall_cnt <= if_stall_cnt + 32'd1;
      else           if_stall_cnt <= if_stall_cnt;
      if (grant_s && (grant_own_s == OWN_D)) d_grant_cnt <= d_grant_cnt + 32'd1;
      else                                   d_grant_cnt <= d_grant_cnt;
    end
  end
`endif

endmodule
